fetch_pipe_ctrl: RTL
====================

Name: fetch_pipe_ctrl

Overview:
- Consumer end of the hazard-control interface. Takes the pc_ld, IF_ID_write, flush and nop controls and applies them to the PC register, the IF/ID pipeline register and the ID/EXE valid bit.
- Selects the next PC (sequential, branch or jump).
- Keeps saturating stall and flush performance counters.
- Raises sticky error flags for a stall lock-up and for inconsistent control inputs.
- Sits between instruction memory and the decode stage.

Parameters:
- WIDTH, 32, width of PC, targets and instruction.
- RESET_PC, 0, PC value after reset.
- STALL_LIMIT, 16, consecutive stall cycles that trip stall_timeout (must be at least 2).
- CNT_WIDTH, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active low.
- pc_ld  in  1  PC load enable (0 = stall).
- IF_ID_write  in  1  IF/ID write enable (0 = stall).
- flush  in  1  squash the instruction being fetched.
- nop  in  1  inject a bubble into ID/EXE.
- jump  in  1  jump resolved in ID.
- branch_taken  in  1  branch resolved taken in ID.
- jump_target  in  WIDTH  jump destination.
- branch_target  in  WIDTH  branch destination.
- instr_in  in  WIDTH  instruction memory data for pc (combinational read).
- pc  out  WIDTH  current fetch address.
- IF_ID_instr  out  WIDTH  decode-stage instruction.
- IF_ID_pc_plus4  out  WIDTH  decode-stage PC+4.
- IF_ID_valid  out  1  decode-stage instruction is real.
- ID_EXE_valid  out  1  execute-stage instruction is real.
- stall_count  out  CNT_WIDTH  cycles with pc_ld=0, saturating.
- flush_count  out  CNT_WIDTH  accepted flushes, saturating.
- stall_timeout  out  1  sticky lock-up flag.
- protocol_err  out  1  sticky pc_ld/IF_ID_write mismatch flag.

Behaviour:
- Reset: synchronous and active low. With rst=0 at a rising edge:
  - pc = RESET_PC.
  - IF_ID_instr = 0, IF_ID_pc_plus4 = 0, IF_ID_valid = 0.
  - ID_EXE_valid = 0.
  - Both counters = 0, stall_timeout = 0, protocol_err = 0.
  - All inputs are ignored; reset mid-stall or mid-flush discards the operation in progress.
- Definitions: stall = ~pc_ld. accept = pc_ld & IF_ID_write.
- Next PC (one-cycle latency), in priority order:
  - stall: hold pc.
  - else jump: jump_target.
  - else branch_taken: branch_target.
  - else pc+4, modulo 2^WIDTH (wrap silently).
  - jump and branch_taken together: jump wins.
- IF/ID register, in priority order:
  - IF_ID_write=0: hold all fields, including valid.
  - else flush=1: IF_ID_instr = 0, IF_ID_pc_plus4 = 0, IF_ID_valid = 0.
  - else: IF_ID_instr = instr_in, IF_ID_pc_plus4 = pc+4, IF_ID_valid = 1.
- Stall dominates flush. When pc_ld=0, flush is ignored that cycle: the branch outcome was computed on stale operands. The redirect and squash take effect on the first non-stalled cycle, when the control inputs are re-presented.
- ID_EXE_valid <= IF_ID_valid & ~nop, every cycle. nop with IF_ID_valid=0 still gives 0.
- stall_count:
  - Increments by 1 on each cycle with pc_ld=0 and rst=1.
  - Saturates at 2^CNT_WIDTH-1.
- flush_count:
  - Increments on each cycle with accept=1 and flush=1.
  - Saturates at 2^CNT_WIDTH-1.
- Stall run counter (internal):
  - Counts consecutive stall cycles; clears on any cycle with pc_ld=1.
  - When it reaches STALL_LIMIT, stall_timeout sets on that edge.
  - stall_timeout stays set until reset. The pipeline is not altered by it.
- protocol_err sets on any cycle with rst=1 and pc_ld != IF_ID_write, and stays set until reset.
- Mismatched controls are still applied as given, each to its own register.
- No combinational path from inputs to outputs; every output is a register.

Test Plan:
- Reset, then 3 free-run cycles with instr_in=32'h1111_0000+pc -> pc steps 0, 4, 8, 12. IF_ID_instr = 32'h1111_0000 then 32'h1111_0004. IF_ID_valid = 1 from cycle 2. ID_EXE_valid = 1 from cycle 3.
- pc=8, pc_ld=IF_ID_write=0 for 2 cycles with nop=1 -> pc holds 8, IF/ID holds, ID_EXE_valid = 0 for 2 cycles, stall_count = 2, protocol_err = 0.
- pc=12, branch_taken=1, branch_target=32'h40, flush=1 -> pc=32'h40, IF_ID_valid=0, IF_ID_instr=0, flush_count=1. Next cycle ID_EXE_valid=0.
- Stall and flush in the same cycle (pc_ld=IF_ID_write=0, flush=1, jump=1, jump_target=32'h80) -> pc and IF/ID hold, flush_count unchanged. Release with flush=1, jump=1 -> pc=32'h80, IF_ID_valid=0.
- With STALL_LIMIT=16: 15 stall cycles, 1 run cycle, 16 stall cycles -> stall_timeout=0 after the first run, 1 on the 16th cycle of the second run. It stays 1 after the stall releases and clears only on rst=0.
- pc_ld=1, IF_ID_write=0 for one cycle -> protocol_err=1, pc advances, IF/ID holds. A mid-stream rst=0 then clears all outputs to reset values.

Source files
------------

// File: rtl/fetch_pipe_if.sv
// Hazard-control / fetch bundle between the hazard unit, instruction memory
// and the fetch/decode pipeline registers.
interface fetch_pipe_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 pc_ld;
    logic                 IF_ID_write;
    logic                 flush;
    logic                 nop;
    logic                 jump;
    logic                 branch_taken;
    logic [WIDTH-1:0]     jump_target;
    logic [WIDTH-1:0]     branch_target;
    logic [WIDTH-1:0]     instr_in;
    logic [WIDTH-1:0]     pc;
    logic [WIDTH-1:0]     IF_ID_instr;
    logic [WIDTH-1:0]     IF_ID_pc_plus4;
    logic                 IF_ID_valid;
    logic                 ID_EXE_valid;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;
    logic                 stall_timeout;
    logic                 protocol_err;

    modport master (
        output pc_ld, IF_ID_write, flush, nop, jump, branch_taken,
        output jump_target, branch_target, instr_in,
        input  pc, IF_ID_instr, IF_ID_pc_plus4, IF_ID_valid, ID_EXE_valid,
        input  stall_count, flush_count, stall_timeout, protocol_err
    );

    modport slave (
        input  pc_ld, IF_ID_write, flush, nop, jump, branch_taken,
        input  jump_target, branch_target, instr_in,
        output pc, IF_ID_instr, IF_ID_pc_plus4, IF_ID_valid, ID_EXE_valid,
        output stall_count, flush_count, stall_timeout, protocol_err
    );
endinterface

// File: rtl/fetch_pipe_ctrl.sv
// Applies hazard controls to PC, IF/ID and ID/EXE valid; keeps stall/flush
// counters and sticky lock-up / control-mismatch flags.
module fetch_pipe_ctrl #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               STALL_LIMIT = 16,
    parameter int               CNT_WIDTH   = 16
) (
    input logic         clk,
    input logic         rst,
    fetch_pipe_if.slave bus
);
    localparam int RW = $clog2(STALL_LIMIT);

    logic             stall;
    logic             accept;
    logic             squash;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] pc_next;
    logic [RW-1:0]    run;

    assign stall    = ~bus.pc_ld;
    assign accept   = bus.pc_ld & bus.IF_ID_write;
    // A stalled cycle saw stale operands, so its flush is not trusted.
    assign squash   = bus.flush & bus.pc_ld;
    assign pc_plus4 = bus.pc + WIDTH'(4);

    always_comb begin
        pc_next = pc_plus4;
        if (stall)
            pc_next = bus.pc;
        else if (bus.jump)
            pc_next = bus.jump_target;
        else if (bus.branch_taken)
            pc_next = bus.branch_target;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.pc             <= RESET_PC;
            bus.IF_ID_instr    <= '0;
            bus.IF_ID_pc_plus4 <= '0;
            bus.IF_ID_valid    <= 1'b0;
            bus.ID_EXE_valid   <= 1'b0;
            bus.stall_count    <= '0;
            bus.flush_count    <= '0;
            bus.stall_timeout  <= 1'b0;
            bus.protocol_err   <= 1'b0;
            run                <= '0;
        end else begin
            bus.pc <= pc_next;
            if (bus.IF_ID_write) begin
                if (squash) begin
                    bus.IF_ID_instr    <= '0;
                    bus.IF_ID_pc_plus4 <= '0;
                    bus.IF_ID_valid    <= 1'b0;
                end else begin
                    bus.IF_ID_instr    <= bus.instr_in;
                    bus.IF_ID_pc_plus4 <= pc_plus4;
                    bus.IF_ID_valid    <= 1'b1;
                end
            end
            bus.ID_EXE_valid <= bus.IF_ID_valid & ~bus.nop;
            if (stall && bus.stall_count != '1)
                bus.stall_count <= bus.stall_count + 1'b1;
            if (accept && bus.flush && bus.flush_count != '1)
                bus.flush_count <= bus.flush_count + 1'b1;
            // run parks at LIMIT-1; every further stall keeps the flag set
            if (stall) begin
                if (run == RW'(STALL_LIMIT - 1))
                    bus.stall_timeout <= 1'b1;
                else
                    run <= run + 1'b1;
            end else begin
                run <= '0;
            end
            if (bus.pc_ld != bus.IF_ID_write)
                bus.protocol_err <= 1'b1;
        end
    end
endmodule
